// File: rtl/aes_pkg.sv
// Shared AES constants and helpers for the key schedule and the decipher datapath.
package aes_pkg;

    localparam logic [3:0]  AES256_ROUNDS    = 4'he;
    localparam int unsigned AES256_NUM_RKEYS = 15;
    localparam logic [7:0]  RCON_INIT        = 8'h01;

    typedef enum logic {
        ST_IDLE,
        ST_GEN
    } ke_state_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gm2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 32-bit forward AES S-box: four parallel byte substitutions.
module aes_sbox (
    input  logic [31:0] sboxw,
    output logic [31:0] new_sboxw
);

    // Byte 0 of the table sits in the most significant byte.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Offset of entry b is (255 - b) * 8, i.e. {~b, 3'b000}.
    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        return SBOX[{~b, 3'b000} +: 8];
    endfunction

    assign new_sboxw[31:24] = sub_byte(sboxw[31:24]);
    assign new_sboxw[23:16] = sub_byte(sboxw[23:16]);
    assign new_sboxw[15:8]  = sub_byte(sboxw[15:8]);
    assign new_sboxw[7:0]   = sub_byte(sboxw[7:0]);

endmodule

// File: rtl/aes_key_expand256.sv
// AES-256 key schedule: expands a key into 15 stored round keys, one per cycle,
// and serves them combinationally by round index.
module aes_key_expand256
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         init,
    input  logic [255:0] key,
    input  logic [3:0]   round,
    output logic [127:0] round_key,
    output logic         ready
);

    ke_state_t    state;
    ke_state_t    state_next;
    logic [127:0] rk [AES256_NUM_RKEYS];
    logic [3:0]   gen_ctr;
    logic [7:0]   rcon;

    logic [31:0]  p1_word;
    logic [127:0] p2;
    logic         even_round;
    logic [31:0]  sbox_in;
    logic [31:0]  sbox_out;
    logic [31:0]  t;
    logic [31:0]  w0, w1, w2, w3;
    logic [127:0] new_rk;

    // Explicit muxes keep the out-of-range counter and round 15 well defined.
    always_comb begin
        p1_word   = '0;
        p2        = '0;
        round_key = '0;
        for (int unsigned i = 0; i < AES256_NUM_RKEYS; i++) begin
            if (4'(i) == gen_ctr - 4'd1) p1_word = rk[i][31:0];
            if (4'(i) == gen_ctr - 4'd2) p2 = rk[i];
            if (4'(i) == round) round_key = rk[i];
        end
    end

    assign even_round = ~gen_ctr[0];
    assign sbox_in    = even_round ? {p1_word[23:0], p1_word[31:24]} : p1_word;

    aes_sbox u_sbox (
        .sboxw     (sbox_in),
        .new_sboxw (sbox_out)
    );

    assign t      = even_round ? (sbox_out ^ {rcon, 24'h0}) : sbox_out;
    assign w0     = p2[127:96] ^ t;
    assign w1     = p2[95:64]  ^ w0;
    assign w2     = p2[63:32]  ^ w1;
    assign w3     = p2[31:0]   ^ w2;
    assign new_rk = {w0, w1, w2, w3};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (init) state_next = ST_GEN;
            ST_GEN:  if (gen_ctr == AES256_ROUNDS) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < AES256_NUM_RKEYS; i++) rk[i] <= '0;
            gen_ctr <= '0;
            rcon    <= RCON_INIT;
            ready   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (init) begin
                        rk[0]   <= key[255:128];
                        rk[1]   <= key[127:0];
                        gen_ctr <= 4'd2;
                        rcon    <= RCON_INIT;
                        ready   <= 1'b0;
                    end
                end
                ST_GEN: begin
                    for (int unsigned i = 0; i < AES256_NUM_RKEYS; i++) begin
                        if (4'(i) == gen_ctr) rk[i] <= new_rk;
                    end
                    gen_ctr <= gen_ctr + 4'd1;
                    if (even_round) rcon <= gm2(rcon);
                    if (gen_ctr == AES256_ROUNDS) ready <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_key_expand256.sv
// Scoreboard bench for aes_key_expand256 against a word-level FIPS-197 key schedule model.
`timescale 1ns/1ps
module tb_aes_key_expand256;

    logic         clk;
    logic         reset_n;
    logic         init;
    logic [255:0] key;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic         ready;

    aes_key_expand256 dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .init      (init),
        .key       (key),
        .round     (round),
        .round_key (round_key),
        .ready     (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   rnd;
        logic [127:0] key;
        logic         rdy;
        string        name;
    } exp_t;

    exp_t         sb[$];
    logic         probe_en;
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [7:0]   sbox_t [256];
    logic [127:0] exp_rk [15];

    function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    // S-box from first principles: multiplicative inverse followed by the affine map.
    function automatic void build_sbox();
        logic [7:0] inv;
        logic [7:0] xb;
        for (int xv = 0; xv < 256; xv++) begin
            xb  = 8'(xv);
            inv = '0;
            for (int y = 1; y < 256; y++) if (gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[xv] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Standard 60-word expansion, Nk = 8.
    function automatic void ref_expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] tmp;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            tmp = w[i-1];
            if (i % 8 == 0) begin
                tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                tmp = sub_word(tmp);
            end
            w[i] = w[i-8] ^ tmp;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    // Monitor: one scoreboard entry is consumed per strobed cycle.
    always @(negedge clk) begin
        if (probe_en) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL scoreboard_underflow: got empty queue expected an entry");
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("%s round_key[%0d]", e.name, e.rnd), round_key, e.key);
                check($sformatf("%s ready", e.name), {127'b0, ready}, {127'b0, e.rdy});
            end
        end
    end

    task automatic probe(input logic [3:0] r, input logic [127:0] e, input logic rdy, input string nm);
        exp_t it;
        it.rnd  = r;
        it.key  = e;
        it.rdy  = rdy;
        it.name = nm;
        sb.push_back(it);
        round    = r;
        probe_en = 1'b1;
        @(negedge clk);
        #1;
        probe_en = 1'b0;
    endtask

    task automatic sweep(input string nm);
        for (int r = 14; r >= 0; r--) probe(4'(r), exp_rk[r], 1'b1, nm);
        probe(4'd15, '0, 1'b1, nm);
    endtask

    task automatic pulse_init(input logic [255:0] k, input string nm);
        init = 1'b1;
        key  = k;
        @(posedge clk);
        #1;
        init = 1'b0;
        key  = rand_key();
        check({nm, " ready_fall"}, {127'b0, ready}, '0);
    endtask

    task automatic wait_ready(input int start, input string nm);
        int cyc;
        cyc = start;
        while (ready !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, " busy_cycles"}, 128'(cyc), 128'd13);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] ka;
        logic [255:0] kb;

        build_sbox();
        reset_n  = 1'b0;
        init     = 1'b0;
        key      = '0;
        round    = '0;
        probe_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int r = 0; r < 16; r++) probe(4'(r), '0, 1'b0, "reset");

        ka = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        ref_expand(ka);
        pulse_init(ka, "c3");
        wait_ready(0, "c3");
        probe(4'd1,  128'h101112131415161718191a1b1c1d1e1f, 1'b1, "c3_kat");
        probe(4'd2,  128'ha573c29fa176c498a97fce93a572c09c, 1'b1, "c3_kat");
        probe(4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36, 1'b1, "c3_kat");
        sweep("c3");

        ka = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        ref_expand(ka);
        pulse_init(ka, "a3");
        wait_ready(0, "a3");
        probe(4'd2, 128'h9ba354118e6925afa51a8b5f2067fcde, 1'b1, "a3_kat");
        sweep("a3");

        for (int n = 0; n < 3; n++) begin
            ka = rand_key();
            ref_expand(ka);
            pulse_init(ka, "rand");
            wait_ready(0, "rand");
            sweep("rand");
        end

        // init during GEN must not disturb the running expansion
        ka = rand_key();
        kb = rand_key();
        ref_expand(ka);
        pulse_init(ka, "ignore");
        repeat (4) @(posedge clk);
        #1;
        init = 1'b1;
        key  = kb;
        @(posedge clk);
        #1;
        init = 1'b0;
        wait_ready(5, "ignore");
        sweep("ignore");

        // back-to-back: re-init on the first edge where ready is high
        ka = rand_key();
        kb = rand_key();
        pulse_init(ka, "b2b_a");
        wait_ready(0, "b2b_a");
        ref_expand(kb);
        pulse_init(kb, "b2b_b");
        wait_ready(0, "b2b_b");
        sweep("b2b_b");

        // asynchronous reset in the middle of generation
        ka = rand_key();
        pulse_init(ka, "midrst");
        repeat (6) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("midrst ready_now", {127'b0, ready}, '0);
        for (int r = 0; r < 16; r++) probe(4'(r), '0, 1'b0, "midrst");
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        kb = rand_key();
        ref_expand(kb);
        pulse_init(kb, "postrst");
        wait_ready(0, "postrst");
        sweep("postrst");

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 128'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_key_expand256.md
# aes_key_expand256

AES-256 key-schedule stage directly upstream of the decipher round block. It takes a 256-bit key, expands it once into all 15 round keys (rounds 0..14), and stores them locally. It then serves `round_key` combinationally for whatever round index the decipher block drives on `round`. The decipher block counts rounds down from 14 to 0, so all keys must exist before the first `next`.

## Interface
Parameters: none. The block is fixed to AES-256: 14 rounds, 15 round keys.

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `init`  in  1  single-cycle request to expand `key`; sampled only in IDLE.
- `key`  in  256  cipher key, FIPS-197 byte order, MSB = byte 0; sampled on the accepted `init` edge only.
- `round`  in  4  round index requested by the decipher block.
- `round_key`  out  128  stored key for `round`, combinational read.
- `ready`  out  1  1 = all 15 keys valid and block idle.

## Operation
- Storage: 15 × 128-bit key registers `rk[0..14]`, a 4-bit generation counter `gen_ctr`, an 8-bit `rcon` register, and a 1-bit FSM.
- FSM has two states:
  - IDLE: `init` = 1 → load `rk[0] = key[255:128]` and `rk[1] = key[127:0]`, set `gen_ctr` = 2, set `rcon` = 8'h01, set `ready` ← 0, move to GEN.
  - GEN: compute and write `rk[gen_ctr]`, then increment `gen_ctr`. When `gen_ctr` = 14, also set `ready` ← 1 and move to IDLE.
- Generation of round r (2..14), with p2 = `rk[r-2]` and p1 = `rk[r-1]`:
  - r even: t = SubWord(RotWord(p1[31:0])) ^ {`rcon`, 24'h0}; after the write, `rcon` ← xtime(`rcon`).
  - r odd: t = SubWord(p1[31:0]); `rcon` unchanged.
  - w0 = p2[127:96] ^ t; w1 = p2[95:64] ^ w0; w2 = p2[63:32] ^ w1; w3 = p2[31:0] ^ w2.
  - `rk[r]` = {w0, w1, w2, w3}.
  - RotWord(a,b,c,d) = (b,c,d,a).
  - `rcon` takes values 01, 02, 04, 08, 10, 20, 40 for r = 2, 4, …, 14; it never reaches the 8'h80 reduction case.
- One 32-bit forward S-box instance serves all rounds, because one word is substituted per cycle.
- `round_key` = `rk[round]` for `round` ≤ 14; returns 128'h0 for `round` 15.
- `init` while in GEN is ignored: no restart and no queueing. The `key` port is don't-care outside the accepting edge.
- During GEN, `round_key` reads return current register contents, which may be stale or partially regenerated. Consumers must wait for `ready` = 1.

## Timing
- Reset values: all `rk` = 0, `gen_ctr` = 0, `rcon` = 8'h01, FSM = IDLE, `ready` = 0 (no valid keys exist yet). `round_key` therefore reads 0.
- Latency from the accepting edge E0:
  - `ready` falls after E0.
  - E1..E13 write rounds 2..14, one per edge.
  - `ready` rises after E13.
  - Total busy window: 13 cycles.
- Re-`init` is accepted on the same edge at which `ready` is first seen high.
- `round_key` has zero latency from `round`: a mux, no register.
- Reset asserted mid-GEN immediately forces all reset values; a new `init` is required afterwards.
- Critical path: p1 word → S-box → 4-stage XOR chain → `rk` write.

## Structure
- Shared package `aes_pkg` holds:
  - `AES256_ROUNDS` = 4'he, shared with the decipher block.
  - `AES256_NUM_RKEYS` = 15.
  - `RCON_INIT` = 8'h01.
  - the `gm2`/xtime function.
- Sub-module `aes_sbox`: a combinational 32-bit forward S-box with ports `sboxw` and `new_sboxw`. It mirrors the existing inverse S-box.
- The FSM, counter and key registers live in this module.

## Test plan
- Reset: hold `reset_n` low then release → `ready` = 0, `round_key` = 0 for every round 0..15.
- FIPS-197 C.3 key 000102…1f:
  - Pulse `init`; `ready` stays low exactly 13 cycles.
  - Expected round keys: round 1 = 101112131415161718191a1b1c1d1e1f, round 2 = a573c29fa176c498a97fce93a572c09c, round 14 = 24fc79ccbf0979e9371ac23c6d68de36.
- FIPS-197 A.3 key 603deb10…0914dff4 → round 2 = 9ba354118e6925afa51a8b5f2067fcde. Compare all 15 keys against a reference-model dump.
- Pulse `init` with key B at cycle 5 of an expansion of key A → B is ignored and the keys of A complete. `init` with B right after `ready` → keys of B, 13-cycle latency again.
- Assert `reset_n` low at cycle 7 of GEN → immediate `ready` = 0 and all keys 0. A following `init` yields a correct schedule.
- `round` = 15 → `round_key` = 0. Sweep `round` 14→0 while idle and check each key combinationally in the same cycle.
